// File: rtl/reg_write_scheduler.sv
// reg_write_scheduler
// Two requesters share the single write path into the flip-flop register
// bank. Port A is the ALU writeback and port B is the load/immediate unit.
// Each port has its own small FIFO. A round-robin arbiter pops at most one
// entry per cycle. The popped entry becomes a registered one-hot load enable
// and registered write data for the bank on the following cycle.
//
// Handshake (both ports): a request is accepted on a rising clk edge when
// x_valid and x_ready are both high. x_ready depends only on FIFO occupancy
// and never on x_valid. The sender holds addr/data steady until it is
// accepted. A request presented during a flush cycle is dropped.
module reg_write_scheduler #(
    parameter int NREGS = 8,
    parameter int DEPTH = 2,
    parameter int DW    = 16,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             a_valid,
    input  logic [AW-1:0]    a_addr,
    input  logic [DW-1:0]    a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [AW-1:0]    b_addr,
    input  logic [DW-1:0]    b_data,
    output logic             b_ready,
    output logic [NREGS-1:0] reg_load,
    output logic [DW-1:0]    reg_wdata,
    output logic             busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Index 0 is port A and index 1 is port B throughout.
    logic [1:0]          in_valid;
    logic [1:0][AW-1:0]  in_addr;
    logic [1:0][DW-1:0]  in_data;
    logic [1:0]          full;
    logic [1:0]          nonempty;
    logic [1:0]          push;
    logic [1:0]          pop;
    logic [1:0][AW-1:0]  head_addr;
    logic [1:0][DW-1:0]  head_data;

    // The round-robin pointer names the port that wins the next tie (0 = A).
    logic rr;
    logic rr_next;
    logic sel;

    assign in_valid = {b_valid, a_valid};
    assign in_addr  = {b_addr, a_addr};
    assign in_data  = {b_data, a_data};

    for (genvar p = 0; p < 2; p++) begin : g_fifo
        logic [AW+DW-1:0] mem [DEPTH];
        logic [PW-1:0]    wr_ptr;
        logic [PW-1:0]    rd_ptr;
        logic [CW-1:0]    cnt;

        assign full[p]      = (cnt == CW'(DEPTH));
        assign nonempty[p]  = (cnt != '0);
        assign push[p]      = in_valid[p] & ~full[p] & ~flush;
        assign head_addr[p] = mem[rd_ptr][AW+DW-1:DW];
        assign head_data[p] = mem[rd_ptr][DW-1:0];

        // Storage needs no reset because the count gates every read.
        always_ff @(posedge clk) begin
            if (push[p]) begin
                mem[wr_ptr] <= {in_addr[p], in_data[p]};
            end
        end

        // Pointers wrap naturally because DEPTH is a power of two.
        // A flush discards all queued entries.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (push[p]) wr_ptr <= wr_ptr + PW'(1);
                if (pop[p])  rd_ptr <= rd_ptr + PW'(1);
                case ({push[p], pop[p]})
                    2'b10:   cnt <= cnt + CW'(1);
                    2'b01:   cnt <= cnt - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    assign a_ready = ~full[0];
    assign b_ready = ~full[1];

    // Arbiter: a lone non-empty port wins. A tie goes to rr, and then rr flips.
    // A flush suppresses the pop and returns rr to port A.
    always_comb begin
        pop     = '0;
        rr_next = rr;
        sel     = 1'b0;
        if (flush) begin
            rr_next = 1'b0;
        end else if (&nonempty) begin
            sel     = rr;
            rr_next = ~rr;
        end else if (nonempty[1]) begin
            sel = 1'b1;
        end
        pop[sel] = ~flush & nonempty[sel];
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr <= 1'b0;
        else     rr <= rr_next;
    end

    // Output stage: a pop becomes a one-cycle load pulse. Register 0 is
    // hardwired zero, so an entry aimed at it uses its slot but writes nothing.
    // The write data holds its value between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_load  <= '0;
            reg_wdata <= '0;
        end else if ((|pop) && (head_addr[sel] != '0)) begin
            reg_load  <= NREGS'(1) << head_addr[sel];
            reg_wdata <= head_data[sel];
        end else begin
            reg_load <= '0;
        end
    end

    assign busy = (|nonempty) | (|reg_load);

endmodule

// File: tb/tb_reg_write_scheduler.sv
// Testbench for reg_write_scheduler.
// A queue-level reference model runs on each rising edge and predicts every
// bank write into exp_q. A monitor on the falling edge pops exp_q and
// compares it against the DUT. The monitor also checks ready and busy
// against the model every cycle. Directed sequences cover reset, a single
// write, contention, full FIFOs, register 0, and flush.
module tb_reg_write_scheduler;
    localparam int NREGS = 8;
    localparam int DEPTH = 2;
    localparam int DW    = 16;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             a_valid;
    logic [AW-1:0]    a_addr;
    logic [DW-1:0]    a_data;
    logic             a_ready;
    logic             b_valid;
    logic [AW-1:0]    b_addr;
    logic [DW-1:0]    b_data;
    logic             b_ready;
    logic [NREGS-1:0] reg_load;
    logic [DW-1:0]    reg_wdata;
    logic             busy;

    reg_write_scheduler #(.NREGS(NREGS), .DEPTH(DEPTH), .DW(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .reg_load(reg_load), .reg_wdata(reg_wdata), .busy(busy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [AW+DW-1:0]    qa[$];
    logic [AW+DW-1:0]    qb[$];
    logic [NREGS+DW-1:0] exp_q[$];
    logic                m_rr;
    logic [NREGS-1:0]    m_load;
    logic                m_acc_a, m_acc_b, m_both, m_have;
    logic [AW+DW-1:0]    m_ent;
    logic [NREGS-1:0]    m_oh;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            exp_q.delete();
            m_rr   = 1'b0;
            m_load = '0;
        end else begin
            m_acc_a = a_valid && (qa.size() < DEPTH) && !flush;
            m_acc_b = b_valid && (qb.size() < DEPTH) && !flush;
            m_load  = '0;
            if (flush) begin
                qa.delete();
                qb.delete();
                m_rr = 1'b0;
            end else begin
                m_both = (qa.size() > 0) && (qb.size() > 0);
                m_have = 1'b0;
                if ((qa.size() > 0) && (!m_both || m_rr == 1'b0)) begin
                    m_ent  = qa.pop_front();
                    m_have = 1'b1;
                end else if (qb.size() > 0) begin
                    m_ent  = qb.pop_front();
                    m_have = 1'b1;
                end
                if (m_both) m_rr = ~m_rr;
                if (m_have && (m_ent[AW+DW-1:DW] != '0)) begin
                    m_oh   = '0;
                    m_oh[m_ent[AW+DW-1:DW]] = 1'b1;
                    m_load = m_oh;
                    exp_q.push_back({m_oh, m_ent[DW-1:0]});
                end
                if (m_acc_a) qa.push_back({a_addr, a_data});
                if (m_acc_b) qb.push_back({b_addr, b_data});
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int a_low_cnt = 0;
    logic [NREGS+DW-1:0] sb_e;

    always @(negedge clk) begin
        if (!rst) begin
            if (!a_ready) a_low_cnt++;
            check("a_ready", a_ready, (qa.size() < DEPTH));
            check("b_ready", b_ready, (qb.size() < DEPTH));
            check("busy", busy, (qa.size() > 0) || (qb.size() > 0) || (m_load != '0));
            if (exp_q.size() > 0) begin
                sb_e = exp_q.pop_front();
                check("sb_load", reg_load, sb_e[NREGS+DW-1:DW]);
                check("sb_wdata", reg_wdata, sb_e[DW-1:0]);
            end else begin
                check("idle_load", reg_load, 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Streams na entries on A and nb on B, holding each until accepted.
    // It records the first load pulse seen so the caller can check who won first.
    task automatic stream(input int na, input int nb,
                          input logic [AW-1:0] aa, input logic [AW-1:0] ab,
                          input logic [DW-1:0] da, input logic [DW-1:0] db,
                          output logic [NREGS-1:0] first);
        int   ia = 0;
        int   ib = 0;
        int   budget = 200;
        logic acc_a, acc_b;
        first = '0;
        while ((ia < na || ib < nb) && budget > 0) begin
            a_valid = (ia < na);
            a_addr  = aa;
            a_data  = da + DW'(ia);
            b_valid = (ib < nb);
            b_addr  = ab;
            b_data  = db + DW'(ib);
            acc_a   = a_valid && a_ready;
            acc_b   = b_valid && b_ready;
            @(negedge clk);
            budget--;
            if (first == '0) first = reg_load;
            if (acc_a) ia++;
            if (acc_b) ib++;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        if (budget == 0) check("stream_timeout", 0, 1);
        repeat (8) begin
            if (first == '0) first = reg_load;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    logic [NREGS-1:0] first;
    int               low_before;

    initial begin
        flush   = 1'b0;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        rst     = 1'b0;
        #1 rst  = 1'b1;
        #1;
        check("rst_load", reg_load, 0);
        check("rst_wdata", reg_wdata, 0);
        check("rst_a_ready", a_ready, 1);
        check("rst_b_ready", b_ready, 1);
        check("rst_busy", busy, 0);
        idle(2);
        #2 rst = 1'b0;
        @(negedge clk);

        // Single write, which checks the latency from accept to load.
        a_valid = 1'b1; a_addr = 3'd3; a_data = 16'hBEEF;
        @(negedge clk);
        a_valid = 1'b0;
        check("single_pre", reg_load, 0);
        @(negedge clk);
        check("single_load", reg_load, 8'h08);
        check("single_wdata", reg_wdata, 16'hBEEF);
        @(negedge clk);
        check("single_done", reg_load, 0);
        check("single_hold", reg_wdata, 16'hBEEF);
        check("single_busy", busy, 0);

        // Contention: both ports push every cycle, and A wins first.
        stream(8, 8, 3'd1, 3'd2, 16'h1110, 16'h2220, first);
        check("contention_first", first, 8'h02);
        check("contention_idle", busy, 0);

        // Full: B keeps the bank busy, so A backs up and a_ready drops.
        low_before = a_low_cnt;
        stream(3, 6, 3'd6, 3'd4, 16'hA000, 16'hB000, first);
        check("full_a_ready_low", (a_low_cnt > low_before), 1);
        check("full_idle", busy, 0);

        // Register 0 is hardwired zero, so the pop produces no load.
        b_valid = 1'b1; b_addr = 3'd0; b_data = 16'hFFFF;
        @(negedge clk);
        b_valid = 1'b0;
        check("r0_busy_queued", busy, 1);
        check("r0_load_a", reg_load, 0);
        @(negedge clk);
        check("r0_load_b", reg_load, 0);
        check("r0_busy_clear", busy, 0);
        // A register-0 entry still uses its arbitration slot.
        stream(1, 1, 3'd0, 3'd7, 16'h0000, 16'h7777, first);
        idle(2);

        // Flush with both FIFOs loaded, keeping valid high through the flush cycle.
        a_valid = 1'b1; a_addr = 3'd1; a_data = 16'hC001;
        b_valid = 1'b1; b_addr = 3'd2; b_data = 16'hC002;
        idle(3);
        flush = 1'b1;
        @(negedge clk);
        flush   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        check("flush_load", reg_load, 0);
        check("flush_busy", busy, 0);
        check("flush_a_ready", a_ready, 1);
        stream(1, 1, 3'd3, 3'd4, 16'h3333, 16'h4444, first);
        check("flush_rr_first", first, 8'h08);

        // rr is now B. Flush with only B queued, then both ports contend.
        b_valid = 1'b1; b_addr = 3'd7; b_data = 16'h7070;
        @(negedge clk);
        b_valid = 1'b0;
        flush   = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush2_busy", busy, 0);
        stream(1, 1, 3'd5, 3'd6, 16'h5555, 16'h6666, first);
        check("flush2_rr_first", first, 8'h20);

        // Asynchronous reset in the middle of a burst.
        a_valid = 1'b1; a_addr = 3'd1; a_data = 16'hD001;
        b_valid = 1'b1; b_addr = 3'd2; b_data = 16'hD002;
        idle(3);
        check("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_load", reg_load, 0);
        check("mid_rst_wdata", reg_wdata, 0);
        check("mid_rst_a_ready", a_ready, 1);
        check("mid_rst_b_ready", b_ready, 1);
        check("mid_rst_busy", busy, 0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        idle(3);
        check("post_rst_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
